// File: rtl/aes_pkg.sv
// AES shared tables, GF(2^8) helpers and key-length constants.
// Byte 0 of any word or block sits in the most significant bits.
package aes_pkg;

  typedef enum logic {KIDLE, KEXP} key_state_e;
  typedef enum logic {IDLE, RUN} data_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // RCON[1..10]; unused slots padded with zero
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic bit key_bits_ok(input int kb);
    return kb == 128 || kb == 192 || kb == 256;
  endfunction

  function automatic int nk_of(input int kb);
    return kb / 32;
  endfunction

  function automatic int nr_of(input int kb);
    return kb / 32 + 6;
  endfunction

  function automatic int nw_of(input int kb);
    return 4 * (kb / 32 + 7);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(
    input logic [7:0] a,
    input logic [3:0] k
  );
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2)
         ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {
      gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
      gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
      gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
      gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)
    };
  endfunction

  // state byte r+4c sits at row r, column c
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]],
            SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Key-load and block handshake bundle between controller and AES core.
// The controller side is master; the core is slave.
interface aes_iter_core_if #(
  parameter int KEY_BITS = 128
);
  logic                key_load;
  logic [KEY_BITS-1:0] key_in;
  logic                key_ready;
  logic                start;
  logic                enc;
  logic [127:0]        din;
  logic                ready;
  logic                busy;
  logic                dout_valid;
  logic [127:0]        dout;

  modport master (
    output key_load, key_in, start, enc, din,
    input  key_ready, ready, busy, dout_valid, dout
  );

  modport slave (
    input  key_load, key_in, start, enc, din,
    output key_ready, ready, busy, dout_valid, dout
  );
endinterface

// File: rtl/aes_key_expand.sv
// One-word-per-cycle AES key schedule into a flop round-key array.
// Round key r is read combinationally as {w[4r] .. w[4r+3]}.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_load,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                busy,
  input  logic [3:0]          rk_idx,
  output logic [127:0]        rk,
  output logic                key_ready,
  output logic                expanding
);
  localparam int NK = nk_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);

  key_state_e  st_q, st_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  j_q, j_d;
  logic [3:0]  rc_q, rc_d;
  logic        rdy_d;
  logic        load;
  logic [31:0] prev, tmp, w_new;
  logic [31:0] w_q [NW];

  assign load = key_load & ~busy;
  assign expanding = (st_q == KEXP);

  // j tracks i mod NK so no divider is needed
  always_comb begin
    prev = w_q[i_q - 6'd1];
    tmp = prev;
    if (j_q == 3'd0)
      tmp = sub_word(rot_word(prev)) ^ {RCON[rc_q], 24'h0};
    else if (NK == 8 && j_q == 3'd4)
      tmp = sub_word(prev);
    w_new = w_q[i_q - 6'(NK)] ^ tmp;
  end

  always_comb begin
    st_d = st_q;
    i_d = i_q;
    j_d = j_q;
    rc_d = rc_q;
    rdy_d = key_ready;
    unique case (1'b1)
      load: begin
        st_d = KEXP;
        i_d = 6'(NK);
        j_d = 3'd0;
        rc_d = 4'd1;
        rdy_d = 1'b0;
      end
      (st_q == KEXP) && !load: begin
        i_d = i_q + 6'd1;
        j_d = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0)
          rc_d = rc_q + 4'd1;
        if (i_q == 6'(NW - 1)) begin
          st_d = KIDLE;
          rdy_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= KIDLE;
      i_q <= '0;
      j_q <= '0;
      rc_q <= 4'd1;
      key_ready <= 1'b0;
    end else begin
      st_q <= st_d;
      i_q <= i_d;
      j_q <= j_d;
      rc_q <= rc_d;
      key_ready <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < NK; k++)
        w_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
    end else if (st_q == KEXP) begin
      w_q[i_q] <= w_new;
    end
  end

  assign rk = {w_q[{rk_idx, 2'd0}], w_q[{rk_idx, 2'd1}],
               w_q[{rk_idx, 2'd2}], w_q[{rk_idx, 2'd3}]};

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 core, one round per clock.
// Encrypt and decrypt share the state register and round counter.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input logic            clk,
  input logic            reset,
  aes_iter_core_if.slave bus
);
  localparam int NR = nr_of(KEY_BITS);

  if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
    $error("KEY_BITS must be 128, 192 or 256");
  end

  data_state_e  st_q, st_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] dout_q, dout_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         enc_q, enc_d;
  logic         vld_q, vld_d;
  logic         key_ready, expanding;
  logic         busy, ready, accept, last;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] sb, sr, mc, isr, isb, ark, imc;
  logic [127:0] enc_out, dec_out, round_out;

  aes_key_expand #(
    .KEY_BITS(KEY_BITS)
  ) u_key_expand (
    .clk       (clk),
    .reset     (reset),
    .key_load  (bus.key_load),
    .key_in    (bus.key_in),
    .busy      (busy),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .key_ready (key_ready),
    .expanding (expanding)
  );

  assign busy = (st_q == RUN);
  assign ready = key_ready & ~busy & ~expanding;
  assign accept = bus.start & ready;
  assign last = (rnd_q == 4'(NR));

  // idle: whitening key; run: key for the round being computed
  assign rk_idx = busy
    ? (enc_q ? rnd_q : 4'(NR) - rnd_q)
    : (bus.enc ? 4'd0 : 4'(NR));

  for (genvar b = 0; b < 16; b++) begin : g_sbox
    assign sb[127-8*b -: 8] = SBOX[blk_q[127-8*b -: 8]];
    assign isb[127-8*b -: 8] = INV_SBOX[isr[127-8*b -: 8]];
  end

  assign sr = shift_rows(sb);
  assign isr = inv_shift_rows(blk_q);
  assign ark = isb ^ rk;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    assign imc[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
  end

  assign enc_out = (last ? sr : mc) ^ rk;
  assign dec_out = last ? ark : imc;
  assign round_out = enc_q ? enc_out : dec_out;

  always_comb begin
    st_d = st_q;
    blk_d = blk_q;
    rnd_d = rnd_q;
    enc_d = enc_q;
    dout_d = dout_q;
    vld_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (accept) begin
          st_d = RUN;
          enc_d = bus.enc;
          blk_d = bus.din ^ rk;
          rnd_d = 4'd1;
        end
      end
      RUN: begin
        blk_d = round_out;
        rnd_d = rnd_q + 4'd1;
        if (last) begin
          st_d = IDLE;
          dout_d = round_out;
          vld_d = 1'b1;
          rnd_d = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      blk_q <= '0;
      rnd_q <= '0;
      enc_q <= 1'b0;
      dout_q <= '0;
      vld_q <= 1'b0;
    end else begin
      st_q <= st_d;
      blk_q <= blk_d;
      rnd_q <= rnd_d;
      enc_q <= enc_d;
      dout_q <= dout_d;
      vld_q <= vld_d;
    end
  end

  assign bus.key_ready = key_ready;
  assign bus.ready = ready;
  assign bus.busy = busy;
  assign bus.dout = dout_q;
  assign bus.dout_valid = vld_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed FIPS-197 vectors against AES-128/192/256 core instances.
// Index 0/1/2 selects the 128/192/256-bit instance.
module tb_aes_iter_core;

  localparam logic [127:0] K_F  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_F = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_F = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic [2:0]   kl = '0;
  logic [2:0]   st = '0;
  logic         enc = 1'b0;
  logic [127:0] din = '0;
  logic [255:0] key = '0;

  logic [2:0]   kr, rdy, bsy, vld;
  logic [127:0] dout_w [3];

  aes_iter_core_if #(.KEY_BITS(128)) b128 ();
  aes_iter_core_if #(.KEY_BITS(192)) b192 ();
  aes_iter_core_if #(.KEY_BITS(256)) b256 ();

  assign b128.key_load = kl[0];
  assign b128.key_in = key[255:128];
  assign b128.start = st[0];
  assign b128.enc = enc;
  assign b128.din = din;
  assign b192.key_load = kl[1];
  assign b192.key_in = key[255:64];
  assign b192.start = st[1];
  assign b192.enc = enc;
  assign b192.din = din;
  assign b256.key_load = kl[2];
  assign b256.key_in = key;
  assign b256.start = st[2];
  assign b256.enc = enc;
  assign b256.din = din;

  assign kr  = {b256.key_ready, b192.key_ready, b128.key_ready};
  assign rdy = {b256.ready, b192.ready, b128.ready};
  assign bsy = {b256.busy, b192.busy, b128.busy};
  assign vld = {b256.dout_valid, b192.dout_valid, b128.dout_valid};
  assign dout_w[0] = b128.dout;
  assign dout_w[1] = b192.dout;
  assign dout_w[2] = b256.dout;

  aes_iter_core #(.KEY_BITS(128)) u128 (
    .clk(clk), .reset(reset), .bus(b128.slave));
  aes_iter_core #(.KEY_BITS(192)) u192 (
    .clk(clk), .reset(reset), .bus(b192.slave));
  aes_iter_core #(.KEY_BITS(256)) u256 (
    .clk(clk), .reset(reset), .bus(b256.slave));

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_key(int s, logic [255:0] k);
    @(negedge clk);
    key = k;
    kl[s] = 1'b1;
    @(negedge clk);
    kl[s] = 1'b0;
  endtask

  // called at the negedge right after the load edge
  task automatic wait_key(int s, int lat, string tag);
    int n = 0;
    int bad = 0;
    while (!kr[s] && n < 200) begin
      if (bsy[s] || rdy[s]) bad++;
      @(negedge clk);
      n++;
    end
    check({tag, "/key_lat"}, 128'(n), 128'(lat));
    check({tag, "/kexp_idle"}, 128'(bad), 128'd0);
  endtask

  task automatic run_block(int s, logic e, logic [127:0] d,
                           logic [127:0] exp, int lat, string tag);
    int n = 0;
    @(negedge clk);
    check({tag, "/ready"}, 128'(rdy[s]), 128'd1);
    enc = e;
    din = d;
    st[s] = 1'b1;
    @(negedge clk);
    st[s] = 1'b0;
    enc = ~e;
    din = ~d;
    check({tag, "/busy"}, 128'(bsy[s]), 128'd1);
    while (!vld[s] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/lat"}, 128'(n), 128'(lat));
    check({tag, "/dout"}, dout_w[s], exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst%0d/flags", s),
            128'({kr[s], bsy[s], vld[s], rdy[s]}), 128'd0);
      check($sformatf("rst%0d/dout", s), dout_w[s], 128'd0);
    end
    reset = 1'b0;

    load_key(0, {K_F, 128'h0});
    wait_key(0, 40, "fips");
    run_block(0, 1'b1, PT_F, CT_F, 10, "fips_enc");
    run_block(0, 1'b0, CT_F, PT_F, 10, "fips_dec");

    load_key(0, {K128, 128'h0});
    wait_key(0, 40, "k128");
    run_block(0, 1'b1, PT_C, CT128, 10, "k128_enc");
    run_block(0, 1'b0, CT128, PT_C, 10, "k128_dec");

    load_key(1, {K192, 64'h0});
    wait_key(1, 46, "k192");
    run_block(1, 1'b1, PT_C, CT192, 12, "k192_enc");
    run_block(1, 1'b0, CT192, PT_C, 12, "k192_dec");

    load_key(2, K256);
    wait_key(2, 52, "k256");
    run_block(2, 1'b1, PT_C, CT256, 14, "k256_enc");
    run_block(2, 1'b0, CT256, PT_C, 14, "k256_dec");

    // start held through RUN, then reused for a back-to-back block
    @(negedge clk);
    enc = 1'b1;
    din = PT_C;
    st[0] = 1'b1;
    @(negedge clk);
    enc = 1'b0;
    din = ~PT_C;
    n = 0;
    bad = 0;
    while (!vld[0] && n < 100) begin
      if (!bsy[0] || dout_w[0] !== PT_C) bad++;
      @(negedge clk);
      n++;
    end
    check("hold/lat", 128'(n), 128'd10);
    check("hold/run_stable", 128'(bad), 128'd0);
    check("hold/dout", dout_w[0], CT128);
    check("b2b/ready", 128'(rdy[0]), 128'd1);
    din = CT128;
    enc = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    din = '0;
    enc = 1'b1;
    check("b2b/busy", 128'(bsy[0]), 128'd1);
    n = 0;
    while (!vld[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b/lat", 128'(n), 128'd10);
    check("b2b/dout", dout_w[0], PT_C);
    @(negedge clk);
    check("b2b/no_extra", 128'({bsy[0], vld[0]}), 128'd0);

    // key_load while busy must be ignored
    @(negedge clk);
    enc = 1'b1;
    din = PT_C;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    key = {K_F, 128'h0};
    kl[0] = 1'b1;
    @(negedge clk);
    kl[0] = 1'b0;
    n = 4;
    while (!vld[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("kl_busy/lat", 128'(n), 128'd10);
    check("kl_busy/dout", dout_w[0], CT128);
    check("kl_busy/key_ready", 128'(kr[0]), 128'd1);
    run_block(0, 1'b1, PT_C, CT128, 10, "kl_busy_again");

    // reload mid-expansion with start held high throughout
    load_key(0, {K128, 128'h0});
    st[0] = 1'b1;
    repeat (15) @(negedge clk);
    load_key(0, {K_F, 128'h0});
    wait_key(0, 40, "reload");
    st[0] = 1'b0;
    check("reload/no_accept", 128'(bsy[0]), 128'd0);
    run_block(0, 1'b1, PT_F, CT_F, 10, "reload_enc");

    // reset in the middle of key expansion
    load_key(2, K256);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_kexp/flags",
          128'({kr[2], bsy[2], vld[2], rdy[2]}), 128'd0);
    check("rst_kexp/dout", dout_w[2], 128'd0);
    repeat (60) @(negedge clk);
    check("rst_kexp/stay_unkeyed", 128'({kr[2], rdy[2]}), 128'd0);

    load_key(2, K256);
    wait_key(2, 52, "rekey256");
    run_block(2, 1'b1, PT_C, CT256, 14, "rekey256_enc");

    // reset in the middle of a block
    @(negedge clk);
    enc = 1'b1;
    din = PT_C;
    st[2] = 1'b1;
    @(negedge clk);
    st[2] = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_run/flags",
          128'({kr[2], bsy[2], vld[2], rdy[2]}), 128'd0);
    check("rst_run/dout", dout_w[2], 128'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vld[2] || rdy[2] || bsy[2]) bad++;
    end
    check("rst_run/quiet", 128'(bad), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
